// File: rtl/shift_add_mul4.sv
// ---------------------------------------------------------------------------
// shift_add_mul4
//   Sequential 4x4 unsigned shift-and-add multiplier producing an 8-bit
//   product. One multiply in flight; start/done handshake. A single 4-bit
//   ripple adder (full_add4) is reused on every iteration.
//
// Ports
//   clk      in   1  rising-edge clock
//   rst      in   1  asynchronous, active-high reset
//   start    in   1  multiply request, honoured only while idle
//   a        in   4  multiplicand, captured with an accepted start
//   b        in   4  multiplier, captured with an accepted start
//   busy     out  1  high whenever a multiply is running or completing
//   done     out  1  one-cycle pulse, product is new and valid
//   product  out  8  last completed a*b, held until the next result
// ---------------------------------------------------------------------------

module full_add4 (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       c_in,
    output logic [3:0] sum,
    output logic       c_out
);
    assign {c_out, sum} = {1'b0, a} + {1'b0, b} + {4'b0000, c_in};
endmodule

module shift_add_mul4 #(
    parameter int WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);
    // The adder instance is hard-wired at 4 bits; reject other widths.
    if (WIDTH != 4) begin : g_width_check
        $error("shift_add_mul4: only WIDTH=4 is supported");
    end

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t               r_state;
    state_t               w_next_state;
    logic [WIDTH-1:0]     r_m;
    logic [WIDTH-1:0]     r_a;
    logic [WIDTH-1:0]     r_q;
    logic [2:0]           r_count;
    logic [2*WIDTH-1:0]   r_product;

    logic [WIDTH-1:0]     w_addend;
    logic [WIDTH-1:0]     w_sum;
    logic                 w_cout;
    logic                 w_last_iter;

    // Multiplier bit selects whether M or zero is added this iteration.
    assign w_addend    = r_q[0] ? r_m : '0;
    assign w_last_iter = (r_count == 3'(WIDTH - 1));

    full_add4 u_add (
        .a     (r_a),
        .b     (w_addend),
        .c_in  (1'b0),
        .sum   (w_sum),
        .c_out (w_cout)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:    if (start) w_next_state = RUN;
            RUN:     if (w_last_iter) w_next_state = DONE;
            DONE:    w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_m       <= '0;
            r_a       <= '0;
            r_q       <= '0;
            r_count   <= '0;
            r_product <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_m     <= a;
                        r_a     <= '0;
                        r_q     <= b;
                        r_count <= '0;
                    end
                end
                RUN: begin
                    // Right shift of {c_out, sum, Q} by one position.
                    r_a     <= {w_cout, w_sum[WIDTH-1:1]};
                    r_q     <= {w_sum[0], r_q[WIDTH-1:1]};
                    r_count <= r_count + 3'd1;
                    // Load the post-shift {A,Q} on the final iteration so the
                    // output never shows a partial product.
                    if (w_last_iter) begin
                        r_product <= {w_cout, w_sum, r_q[WIDTH-1:1]};
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy    = (r_state != IDLE);
    assign done    = (r_state == DONE);
    assign product = r_product;

endmodule

// File: tb/tb_shift_add_mul4.sv
// ---------------------------------------------------------------------------
// tb_shift_add_mul4
//   Self-checking bench for shift_add_mul4. Expected products are pushed to a
//   scoreboard queue when a start is issued and popped when done appears.
//   Inputs are driven 1 ns after each rising edge and outputs sampled there.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_shift_add_mul4;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [3:0] a;
    logic [3:0] b;
    logic       busy;
    logic       done;
    logic [7:0] product;

    int         n_vec = 0;
    int         n_err = 0;
    logic [7:0] exp_q[$];

    shift_add_mul4 #(.WIDTH(4)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .a       (a),
        .b       (b),
        .busy    (busy),
        .done    (done),
        .product (product)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present start for exactly one edge and record the expected product.
    task automatic issue(input logic [3:0] ia, input logic [3:0] ib);
        logic [7:0] p;
        p = 8'(ia) * 8'(ib);
        a     = ia;
        b     = ib;
        start = 1'b1;
        exp_q.push_back(p);
        tick();
        start = 1'b0;
    endtask

    // Advance until done is seen or the budget runs out; returns edges taken.
    task automatic wait_done(output int edges);
        edges = 0;
        while (!done && edges < 20) begin
            tick();
            edges++;
        end
    endtask

    task automatic pop_exp(output logic [7:0] e);
        if (exp_q.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL scoreboard_empty: actual empty queue, required an entry");
            e = 8'h00;
        end else begin
            e = exp_q.pop_front();
        end
    endtask

    task automatic test_reset();
        logic [2:0] obs;
        rst = 1'b1; start = 1'b1; a = 4'hF; b = 4'hF;
        tick(); tick();
        obs = {busy, done, 1'b0};
        n_vec++;
        if (obs !== 3'b000 || product !== 8'h00) begin
            n_err++;
            $display("FAIL reset_state: actual busy=%b done=%b product=%h, required 0 0 00",
                     busy, done, product);
        end
        start = 1'b0;
        rst   = 1'b0;
        tick();
        n_vec++;
        if (busy !== 1'b0) begin
            n_err++;
            $display("FAIL reset_release_idle: actual busy=%b, required 0", busy);
        end
    endtask

    task automatic test_max();
        int         edges;
        int         busy_cycles;
        logic [7:0] e;
        issue(4'd15, 4'd15);
        busy_cycles = busy ? 1 : 0;
        edges = 0;
        while (!done && edges < 20) begin
            tick();
            edges++;
            if (busy) busy_cycles++;
        end
        n_vec++;
        if (edges !== 4) begin
            n_err++;
            $display("FAIL max_latency: actual %0d edges, required 4", edges);
        end
        pop_exp(e);
        n_vec++;
        if (product !== e) begin
            n_err++;
            $display("FAIL max_product: actual %h, required %h", product, e);
        end
        tick();
        n_vec++;
        if (busy_cycles !== 5 || busy !== 1'b0 || done !== 1'b0) begin
            n_err++;
            $display("FAIL max_busy_window: actual busy_cycles=%0d busy=%b done=%b, required 5 0 0",
                     busy_cycles, busy, done);
        end
        tick(); tick();
        n_vec++;
        if (product !== 8'hE1) begin
            n_err++;
            $display("FAIL max_hold: actual %h, required e1", product);
        end
    endtask

    task automatic test_basic();
        logic [3:0] ta[3] = '{4'd13, 4'd0, 4'd1};
        logic [3:0] tb[3] = '{4'd11, 4'd9, 4'd15};
        int         edges;
        logic [7:0] e;
        for (int i = 0; i < 3; i++) begin
            issue(ta[i], tb[i]);
            wait_done(edges);
            pop_exp(e);
            n_vec++;
            if (edges !== 4 || product !== e) begin
                n_err++;
                $display("FAIL basic_%0d: actual edges=%0d product=%h, required 4 %h",
                         i, edges, product, e);
            end
            tick();
            n_vec++;
            if (done !== 1'b0) begin
                n_err++;
                $display("FAIL basic_pulse_%0d: actual done=%b, required 0", i, done);
            end
        end
    endtask

    task automatic test_ignored_start();
        int         edges;
        logic [7:0] e;
        issue(4'd6, 4'd7);
        tick();
        a = 4'd3; b = 4'd3; start = 1'b1;   // sampled while running
        tick();
        start = 1'b0;
        wait_done(edges);
        pop_exp(e);
        n_vec++;
        if (edges !== 2 || product !== e) begin
            n_err++;
            $display("FAIL ignore_run: actual edges=%0d product=%h, required 2 %h",
                     edges, product, e);
        end
        start = 1'b1;                       // sampled while in DONE
        tick();
        start = 1'b0;
        tick();
        n_vec++;
        if (busy !== 1'b0 || done !== 1'b0 || product !== 8'h2A) begin
            n_err++;
            $display("FAIL ignore_done: actual busy=%b done=%b product=%h, required 0 0 2a",
                     busy, done, product);
        end
        issue(4'd3, 4'd3);
        wait_done(edges);
        pop_exp(e);
        n_vec++;
        if (edges !== 4 || product !== e) begin
            n_err++;
            $display("FAIL ignore_next: actual edges=%0d product=%h, required 4 %h",
                     edges, product, e);
        end
        tick();
    endtask

    task automatic test_input_change();
        int         edges;
        logic [7:0] e;
        issue(4'd12, 4'd12);
        edges = 0;
        while (!done && edges < 20) begin
            a = 4'($urandom);
            b = 4'($urandom);
            tick();
            edges++;
        end
        pop_exp(e);
        n_vec++;
        if (edges !== 4 || product !== e) begin
            n_err++;
            $display("FAIL input_change: actual edges=%0d product=%h, required 4 %h",
                     edges, product, e);
        end
        tick();
    endtask

    task automatic test_reset_mid();
        int         edges;
        logic [7:0] e;
        issue(4'd15, 4'd15);
        tick(); tick();                     // after E2
        #2;
        rst = 1'b1;
        #1;                                 // still before E3
        n_vec++;
        if (busy !== 1'b0 || done !== 1'b0 || product !== 8'h00) begin
            n_err++;
            $display("FAIL reset_async: actual busy=%b done=%b product=%h, required 0 0 00",
                     busy, done, product);
        end
        void'(exp_q.pop_back());            // aborted multiply never completes
        start = 1'b1; a = 4'd7; b = 4'd7;   // start during reset must lose
        tick();
        start = 1'b0;
        rst   = 1'b0;
        tick();
        n_vec++;
        if (busy !== 1'b0 || product !== 8'h00) begin
            n_err++;
            $display("FAIL reset_wins: actual busy=%b product=%h, required 0 00", busy, product);
        end
        issue(4'd2, 4'd5);
        wait_done(edges);
        pop_exp(e);
        n_vec++;
        if (edges !== 4 || product !== e) begin
            n_err++;
            $display("FAIL reset_fresh: actual edges=%0d product=%h, required 4 %h",
                     edges, product, e);
        end
        tick();
    endtask

    task automatic test_back_to_back();
        int         edges;
        int         bad = 0;
        logic [7:0] e;
        for (int i = 0; i < 256; i++) begin
            issue(4'(i >> 4), 4'(i));
            wait_done(edges);
            pop_exp(e);
            n_vec++;
            if (edges !== 4 || product !== e) begin
                n_err++;
                if (bad < 8)
                    $display("FAIL sweep_%0d_x_%0d: actual edges=%0d product=%h, required 4 %h",
                             i >> 4, i & 15, edges, product, e);
                bad++;
            end
            tick();
            n_vec++;
            if (done !== 1'b0 || busy !== 1'b0) begin
                n_err++;
                if (bad < 8)
                    $display("FAIL sweep_pulse_%0d: actual done=%b busy=%b, required 0 0",
                             i, done, busy);
                bad++;
            end
        end
        n_vec++;
        if (exp_q.size() !== 0) begin
            n_err++;
            $display("FAIL scoreboard_drain: actual %0d left, required 0", exp_q.size());
        end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; a = '0; b = '0;
        test_reset();
        test_max();
        test_basic();
        test_ignored_start();
        test_input_change();
        test_reset_mid();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
